// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register numbers, hazard-FSM states and the
// per-cycle pipeline control bundle driven by pipe_ctrl.
package lc3b_types;

  localparam int unsigned REG_W       = 3;
  localparam int unsigned STALL_CNT_W = 16;

  typedef logic [REG_W-1:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DMEM_WAIT  = 2'd1,
    IMEM_WAIT  = 2'd2,
    REDIR_WAIT = 2'd3
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic pc_redirect;
  } pipe_ctl_t;

  // Builds a control bundle from {pc,if_id,id_ex,ex_mem,mem_wb} loads,
  // {if_id,id_ex,ex_mem} flushes and the redirect select.
  function automatic pipe_ctl_t mk_ctl(input logic [4:0] loads,
                                       input logic [2:0] flushes,
                                       input logic       redirect);
    return pipe_ctl_t'({loads, flushes, redirect});
  endfunction

  localparam pipe_ctl_t CTL_RESET      = mk_ctl(5'b11111, 3'b111, 1'b0);
  localparam pipe_ctl_t CTL_ADVANCE    = mk_ctl(5'b11111, 3'b000, 1'b0);
  localparam pipe_ctl_t CTL_FREEZE     = mk_ctl(5'b00000, 3'b000, 1'b0);
  localparam pipe_ctl_t CTL_BRANCH     = mk_ctl(5'b11111, 3'b111, 1'b1);
  localparam pipe_ctl_t CTL_BUBBLE     = mk_ctl(5'b00111, 3'b010, 1'b0);
  localparam pipe_ctl_t CTL_FETCH_HOLD = mk_ctl(5'b01111, 3'b100, 1'b0);

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds a source
// operand of the instruction currently in ID.
module lu_detect
  import lc3b_types::*;
(
  input  logic    ex_mem_read_i,
  input  logic    ex_regwrite_i,
  input  lc3b_reg dest_ex_i,
  input  lc3b_reg src1_id_i,
  input  lc3b_reg src2_id_i,
  input  logic    use_src1_id_i,
  input  logic    use_src2_id_i,
  output logic    load_use_o
);

  logic hit1;
  logic hit2;

  assign hit1       = use_src1_id_i & (src1_id_i == dest_ex_i);
  assign hit2       = use_src2_id_i & (src2_id_i == dest_ex_i);
  assign load_use_o = ex_mem_read_i & ex_regwrite_i & (hit1 | hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// LC-3b pipeline hazard controller: memory-stall freeze, branch redirect,
// load-use bubble and fetch stall, plus a saturating stall-cycle counter.
module pipe_ctrl
  import lc3b_types::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  lc3b_reg                dest_EX,
  input  logic                   ex_mem_read,
  input  logic                   ex_regwrite,
  input  lc3b_reg                src1_ID,
  input  lc3b_reg                src2_ID,
  input  logic                   use_src1_ID,
  input  logic                   use_src2_ID,
  input  logic                   imem_resp,
  input  logic                   dmem_req,
  input  logic                   dmem_resp,
  input  logic                   br_taken_MEM,
  input  logic                   stall_clr,
  output logic                   load_pc,
  output logic                   load_if_id,
  output logic                   load_id_ex,
  output logic                   load_ex_mem,
  output logic                   load_mem_wb,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   flush_ex_mem,
  output logic                   pc_redirect,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             state
);

  pipe_ctrl_state_t       state_q;
  pipe_ctrl_state_t       state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;
  pipe_ctl_t              ctl;
  logic                   load_use;
  logic                   dmem_stall;

  lu_detect u_lu_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_regwrite_i (ex_regwrite),
    .dest_ex_i     (dest_EX),
    .src1_id_i     (src1_ID),
    .src2_id_i     (src2_ID),
    .use_src1_id_i (use_src1_ID),
    .use_src2_id_i (use_src2_ID),
    .load_use_o    (load_use)
  );

  // Once waiting on data memory, only the response releases the freeze.
  assign dmem_stall = (dmem_req | (state_q == DMEM_WAIT)) & ~dmem_resp;

  // Control outputs and next state, in hazard priority order.
  always_comb begin
    ctl     = CTL_ADVANCE;
    state_d = RUN;
    if (!reset_n) begin
      ctl     = CTL_RESET;
      state_d = RUN;
    end else if (dmem_stall) begin
      ctl     = CTL_FREEZE;
      // A freeze while a redirect is outstanding must not drop the redirect.
      state_d = (state_q == REDIR_WAIT) ? REDIR_WAIT : DMEM_WAIT;
    end else if (state_q == REDIR_WAIT) begin
      ctl     = CTL_FETCH_HOLD;
      state_d = REDIR_WAIT;
      if (imem_resp) begin
        ctl.load_pc     = 1'b1;
        ctl.pc_redirect = 1'b1;
        state_d         = RUN;
      end
    end else if (br_taken_MEM) begin
      ctl     = CTL_BRANCH;
      state_d = RUN;
      if (!imem_resp) begin
        ctl.load_pc     = 1'b0;
        ctl.pc_redirect = 1'b0;
        state_d         = REDIR_WAIT;
      end
    end else if (load_use) begin
      ctl     = CTL_BUBBLE;
      state_d = ((state_q == IMEM_WAIT) && !imem_resp) ? IMEM_WAIT : RUN;
    end else if (!imem_resp) begin
      ctl     = CTL_FETCH_HOLD;
      state_d = IMEM_WAIT;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (!ctl.load_pc && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign load_pc      = ctl.load_pc;
  assign load_if_id   = ctl.load_if_id;
  assign load_id_ex   = ctl.load_id_ex;
  assign load_ex_mem  = ctl.load_ex_mem;
  assign load_mem_wb  = ctl.load_mem_wb;
  assign flush_if_id  = ctl.flush_if_id;
  assign flush_id_ex  = ctl.flush_id_ex;
  assign flush_ex_mem = ctl.flush_ex_mem;
  assign pc_redirect  = ctl.pc_redirect;
  assign stall_cnt    = stall_cnt_q;
  assign state        = 2'(state_q);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus constrained-random
// traffic checked cycle by cycle against a rule-level reference model.
module tb_pipe_ctrl;
  import lc3b_types::*;

  // Expected control vectors {pc,ifid,idex,exmem,memwb, f_ifid,f_idex,f_exmem, redir}
  localparam logic [8:0] O_RESET  = 9'b11111_111_0;
  localparam logic [8:0] O_ADV    = 9'b11111_000_0;
  localparam logic [8:0] O_FREEZE = 9'b00000_000_0;
  localparam logic [8:0] O_BR_OK  = 9'b11111_111_1;
  localparam logic [8:0] O_BR_WT  = 9'b01111_111_0;
  localparam logic [8:0] O_LU     = 9'b00111_010_0;
  localparam logic [8:0] O_IHOLD  = 9'b01111_100_0;
  localparam logic [8:0] O_REDIR  = 9'b11111_100_1;

  logic        clk;
  logic        reset_n;
  lc3b_reg     dest_EX, src1_ID, src2_ID;
  logic        ex_mem_read, ex_regwrite, use_src1_ID, use_src2_ID;
  logic        imem_resp, dmem_req, dmem_resp, br_taken_MEM, stall_clr;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect;
  logic [15:0] stall_cnt;
  logic [1:0]  state;
  logic [8:0]  dut_o;

  int          n_chk;
  int          n_err;
  logic [1:0]  m_st;
  logic [15:0] m_cnt;

  pipe_ctrl dut (
    .clk(clk), .reset_n(reset_n), .dest_EX(dest_EX), .ex_mem_read(ex_mem_read),
    .ex_regwrite(ex_regwrite), .src1_ID(src1_ID), .src2_ID(src2_ID),
    .use_src1_ID(use_src1_ID), .use_src2_ID(use_src2_ID), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .br_taken_MEM(br_taken_MEM),
    .stall_clr(stall_clr), .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pc_redirect(pc_redirect), .stall_cnt(stall_cnt), .state(state)
  );

  assign dut_o = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what the pipeline must do this cycle, from the hazard rules.
  function automatic void ref_eval(output logic [8:0] o, output logic [1:0] ns);
    bit lu;
    bit frozen;
    lu = ex_mem_read && ex_regwrite &&
         ((use_src1_ID && (src1_ID == dest_EX)) || (use_src2_ID && (src2_ID == dest_EX)));
    frozen = (m_st == DMEM_WAIT) ? !dmem_resp : (dmem_req && !dmem_resp);
    if (!reset_n) begin
      o = O_RESET;  ns = RUN;
    end else if (m_st == REDIR_WAIT) begin
      if (frozen)          begin o = O_FREEZE; ns = REDIR_WAIT; end
      else if (!imem_resp) begin o = O_IHOLD;  ns = REDIR_WAIT; end
      else                 begin o = O_REDIR;  ns = RUN;        end
    end else if (frozen) begin
      o = O_FREEZE; ns = DMEM_WAIT;
    end else if (br_taken_MEM) begin
      o  = imem_resp ? O_BR_OK : O_BR_WT;
      ns = imem_resp ? RUN : REDIR_WAIT;
    end else if (lu) begin
      o  = O_LU;
      ns = (m_st == IMEM_WAIT && !imem_resp) ? IMEM_WAIT : RUN;
    end else if (!imem_resp) begin
      o = O_IHOLD; ns = IMEM_WAIT;
    end else begin
      o = O_ADV;   ns = RUN;
    end
  endfunction

  task automatic idle();
    dest_EX = '0; src1_ID = '0; src2_ID = '0;
    ex_mem_read = 0; ex_regwrite = 0; use_src1_ID = 0; use_src2_ID = 0;
    imem_resp = 1; dmem_req = 0; dmem_resp = 0; br_taken_MEM = 0; stall_clr = 0;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle(input string tag);
    logic [8:0] eo;
    logic [1:0] ens;
    #1;
    chk({tag, "/state"}, 32'(state), 32'(m_st));
    chk({tag, "/cnt"}, 32'(stall_cnt), 32'(m_cnt));
    ref_eval(eo, ens);
    chk({tag, "/ctl"}, 32'(dut_o), 32'(eo));
    @(posedge clk);
    if (reset_n) begin
      m_st = ens;
      if (stall_clr)                        m_cnt = 16'h0;
      else if (!eo[8] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in mid-cycle, released on a later negedge.
  task automatic apply_reset(input string tag);
    #2 reset_n = 0;
    #1;
    chk({tag, "/st"}, 32'(state), 32'(RUN));
    chk({tag, "/cnt"}, 32'(stall_cnt), 32'h0);
    chk({tag, "/ctl"}, 32'(dut_o), 32'(O_RESET));
    m_st = RUN; m_cnt = 16'h0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic rand_inputs();
    stall_clr = ($urandom_range(0, 15) == 0);
    imem_resp = ($urandom_range(0, 2) != 0);
    dmem_resp = 1'($urandom_range(0, 1));
    if (m_st == DMEM_WAIT) begin
      dmem_req = 1;  // stalled MEM instruction and everything behind it hold still
    end else begin
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1));
      use_src1_ID = 1'($urandom_range(0, 1));
      use_src2_ID = 1'($urandom_range(0, 1));
      dest_EX     = 3'($urandom_range(0, 3));
      src1_ID     = 3'($urandom_range(0, 3));
      src2_ID     = 3'($urandom_range(0, 3));
      if (m_st == REDIR_WAIT) begin
        br_taken_MEM = 0; dmem_req = 0;
      end else begin
        br_taken_MEM = ($urandom_range(0, 4) == 0);
        dmem_req     = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_st = RUN; m_cnt = 16'h0;
    reset_n = 0;
    idle();
    @(negedge clk);
    #1 chk("rst_ctl", 32'(dut_o), 32'(O_RESET));
    cycle("rst");
    reset_n = 1;

    // Load-use on r1 via src1
    stall_clr = 1; cycle("clr0"); stall_clr = 0;
    ex_mem_read = 1; ex_regwrite = 1; dest_EX = 3'd1; src1_ID = 3'd1; use_src1_ID = 1;
    #1;
    chk("lu_pc", 32'(load_pc), 32'h0);
    chk("lu_ifid", 32'(load_if_id), 32'h0);
    chk("lu_fidex", 32'(flush_id_ex), 32'h1);
    cycle("lu");
    idle();
    #1;
    chk("lu_after_pc", 32'(load_pc), 32'h1);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    cycle("lu_after");

    // Data-memory stall for three cycles
    stall_clr = 1; cycle("clr1"); stall_clr = 0;
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dm_loads", 32'(dut_o[8:4]), 32'h0);
      cycle("dm");
    end
    dmem_resp = 1;
    #1;
    chk("dm_wait_state", 32'(state), 32'(DMEM_WAIT));
    chk("dm_resp_loads", 32'(dut_o[8:4]), 32'h1F);
    cycle("dm_resp");
    idle();
    #1;
    chk("dm_run_state", 32'(state), 32'(RUN));
    chk("dm_stall_cnt", 32'(stall_cnt), 32'h3);
    cycle("dm_after");

    // Branch while the fetch is outstanding
    stall_clr = 1; cycle("clr2"); stall_clr = 0;
    br_taken_MEM = 1; imem_resp = 0;
    #1;
    chk("br_pc", 32'(load_pc), 32'h0);
    chk("br_redir", 32'(pc_redirect), 32'h0);
    chk("br_flush", 32'(dut_o[3:1]), 32'h7);
    cycle("br");
    br_taken_MEM = 0;
    #1;
    chk("rw_state", 32'(state), 32'(REDIR_WAIT));
    chk("rw_ctl", 32'(dut_o), 32'(O_IHOLD));
    cycle("rw");
    imem_resp = 1;
    #1;
    chk("rw_redir", 32'(pc_redirect), 32'h1);
    chk("rw_pc", 32'(load_pc), 32'h1);
    chk("rw_fifid", 32'(flush_if_id), 32'h1);
    cycle("rw_resp");
    #1;
    chk("rw_run_state", 32'(state), 32'(RUN));
    chk("rw_stall_cnt", 32'(stall_cnt), 32'h2);
    cycle("rw_after");

    // Branch and load-use deferred behind a data-memory stall
    dmem_req = 1; br_taken_MEM = 1;
    ex_mem_read = 1; ex_regwrite = 1; dest_EX = 3'd5; src2_ID = 3'd5; use_src2_ID = 1;
    #1 chk("defer_freeze", 32'(dut_o), 32'(O_FREEZE));
    cycle("defer0");
    cycle("defer1");
    dmem_resp = 1;
    #1 chk("defer_branch", 32'(dut_o), 32'(O_BR_OK));
    cycle("defer_resp");
    idle();
    cycle("defer_after");

    // Counter saturation and clear
    stall_clr = 1; cycle("clr3"); stall_clr = 0;
    imem_resp = 0;
    for (int i = 0; i < 65534; i++) cycle("sat_fill");
    #1 chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) cycle("sat");
    #1 chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    stall_clr = 1;
    cycle("sat_clr");
    stall_clr = 0;
    #1 chk("sat_cleared", 32'(stall_cnt), 32'h0);
    cycle("imem_hold0");
    cycle("imem_hold1");

    // Reset from IMEM_WAIT
    chk("pre_rst_state", 32'(state), 32'(IMEM_WAIT));
    apply_reset("rst_imem");
    idle();
    #1;
    chk("post_rst_redir", 32'(pc_redirect), 32'h0);
    chk("post_rst_state", 32'(state), 32'(RUN));
    cycle("post_rst");

    // Constrained-random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) apply_reset("rnd_rst");
      rand_inputs();
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
